// File: rtl/my_video_filter_pkg.sv
// rtl/my_video_filter_pkg.sv - shared width, signedness and saturation-limit helpers
package my_video_filter_pkg;

    // Wide enough for any limit value the multiplier can be configured to need.
    localparam int LIM_W = 256;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic bit result_signed(input bit a_signed, input bit b_signed);
        return a_signed || b_signed;
    endfunction

    function automatic logic signed [LIM_W-1:0] dout_max(input int w, input bit sgn);
        logic signed [LIM_W-1:0] one;
        one = LIM_W'(1);
        return sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
    endfunction

    function automatic logic signed [LIM_W-1:0] dout_min(input int w, input bit sgn);
        logic signed [LIM_W-1:0] one;
        one = LIM_W'(1);
        return sgn ? -(one <<< (w - 1)) : LIM_W'(0);
    endfunction

endpackage

// File: rtl/my_video_filter_mul_pipe_stage.sv
// rtl/my_video_filter_mul_pipe_stage.sv - one pipeline rank: valid bit, data register, load control
module my_video_filter_mul_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         load_next,
    output logic         valid,
    output logic [W-1:0] data
);

    logic load;

    // An empty rank always loads, which is what collapses bubbles.
    assign load = ~valid | load_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/my_video_filter_mul_pipe.sv
// rtl/my_video_filter_mul_pipe.sv - pipelined signed/unsigned multiplier with round, shift, saturate
module my_video_filter_mul_pipe
    import my_video_filter_pkg::*;
#(
    parameter int A_W       = 16,
    parameter int B_W       = 16,
    parameter bit A_SIGNED  = 1'b0,
    parameter bit B_SIGNED  = 1'b0,
    parameter int NUM_STAGE = 3,
    parameter int SHIFT     = 0,
    parameter bit ROUND     = 1'b0,
    parameter bit SAT       = 1'b0,
    parameter int DOUT_W    = 32,
    parameter int USER_W    = 2
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [A_W-1:0]    in_a,
    input  logic [B_W-1:0]    in_b,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_p,
    output logic              out_sat,
    output logic [USER_W-1:0] out_user
);

    localparam int P_W    = prod_width(A_W, B_W);
    localparam bit RES_S  = result_signed(A_SIGNED, B_SIGNED);
    // Two guard bits: one for the rounding carry, one so unsigned values stay positive.
    localparam int X_W    = P_W + 2;
    localparam int D_W    = 1 + DOUT_W + USER_W;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [X_W-1:0] RND     = (ROUND && SHIFT > 0) ? (X_W'(1) <<< RND_SH) : X_W'(0);
    localparam logic signed [X_W-1:0] LIM_MAX = X_W'(dout_max(DOUT_W, RES_S));
    localparam logic signed [X_W-1:0] LIM_MIN = X_W'(dout_min(DOUT_W, RES_S));

    logic signed [X_W-1:0] a_x;
    logic signed [X_W-1:0] b_x;
    logic signed [X_W-1:0] prod;
    logic signed [X_W-1:0] q;
    logic [DOUT_W-1:0]     p_res;
    logic                  sat_res;

    always_comb begin
        if (A_SIGNED) a_x = X_W'($signed(in_a));
        else          a_x = X_W'({1'b0, in_a});
        if (B_SIGNED) b_x = X_W'($signed(in_b));
        else          b_x = X_W'({1'b0, in_b});

        prod    = a_x * b_x;
        q       = (prod + RND) >>> SHIFT;
        p_res   = q[DOUT_W-1:0];
        sat_res = 1'b0;

        if (SAT) begin
            if (q > LIM_MAX) begin
                p_res   = LIM_MAX[DOUT_W-1:0];
                sat_res = 1'b1;
            end else if (q < LIM_MIN) begin
                p_res   = LIM_MIN[DOUT_W-1:0];
                sat_res = 1'b1;
            end
        end
    end

    // Index 0 is the upstream port; index k is rank k.
    logic [NUM_STAGE:0] rank_v;
    logic [D_W-1:0]     rank_data [NUM_STAGE+1];
    logic [NUM_STAGE:1] load_next;
    logic               load_first;

    assign rank_v[0]    = in_valid;
    assign rank_data[0] = {sat_res, p_res, in_user};

    // Unrolled form of load[k] = !v[k] || load[k+1]: a rank's successor can take
    // data unless every rank from there to the output is full and stalled.
    always_comb begin
        logic full;
        full = 1'b1;
        for (int k = NUM_STAGE; k >= 1; k--) begin
            load_next[k] = out_ready | ~full;
            full         = full & rank_v[k];
        end
        load_first = out_ready | ~full;
    end

    for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_rank
        my_video_filter_mul_pipe_stage #(
            .W(D_W)
        ) u_rank (
            .clk      (ap_clk),
            .rst_n    (ap_rst_n),
            .up_valid (rank_v[k-1]),
            .up_data  (rank_data[k-1]),
            .load_next(load_next[k]),
            .valid    (rank_v[k]),
            .data     (rank_data[k])
        );
    end

    assign in_ready                     = ap_rst_n & load_first;
    assign out_valid                    = rank_v[NUM_STAGE];
    assign {out_sat, out_p, out_user}   = rank_data[NUM_STAGE];

endmodule

// File: tb/tb_my_video_filter_mul_pipe.sv
// tb/tb_my_video_filter_mul_pipe.sv - directed vectors and stream sequences for the multiplier pipe
module tb_my_video_filter_mul_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] in_a, in_b;
    logic [1:0]  in_user;
    logic        iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2, os0, os1, os2;
    logic [31:0] op0;
    logic [7:0]  op1, op2;
    logic [1:0]  ou0, ou1, ou2;

    logic [7:0]  a3, b3;
    logic [1:0]  u3, ou3;
    logic        iv3, ir3, ov3, or3, os3;
    logic [9:0]  op3;

    my_video_filter_mul_pipe u_dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .in_a(in_a), .in_b(in_b), .in_user(in_user), .out_valid(ov0), .out_ready(1'b1),
        .out_p(op0), .out_sat(os0), .out_user(ou0));

    my_video_filter_mul_pipe #(
        .A_W(8), .B_W(8), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .NUM_STAGE(1),
        .SHIFT(7), .ROUND(1'b1), .SAT(1'b1), .DOUT_W(8), .USER_W(2)
    ) u_dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_user(in_user), .out_valid(ov1), .out_ready(1'b1),
        .out_p(op1), .out_sat(os1), .out_user(ou1));

    my_video_filter_mul_pipe #(
        .A_W(4), .B_W(4), .A_SIGNED(1'b0), .B_SIGNED(1'b1), .NUM_STAGE(2),
        .SHIFT(0), .ROUND(1'b0), .SAT(1'b0), .DOUT_W(8), .USER_W(2)
    ) u_dut2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_user(in_user), .out_valid(ov2), .out_ready(1'b1),
        .out_p(op2), .out_sat(os2), .out_user(ou2));

    my_video_filter_mul_pipe #(
        .A_W(8), .B_W(8), .A_SIGNED(1'b1), .B_SIGNED(1'b0), .NUM_STAGE(4),
        .SHIFT(3), .ROUND(1'b1), .SAT(1'b1), .DOUT_W(10), .USER_W(2)
    ) u_dut3 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
        .in_a(a3), .in_b(b3), .in_user(u3), .out_valid(ov3), .out_ready(or3),
        .out_p(op3), .out_sat(os3), .out_user(ou3));

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  user;
        logic [31:0] p;
        logic        sat;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic outs(input int sel, output logic v, output logic [31:0] p,
                        output logic s, output logic [1:0] u, output logic r);
        case (sel)
            0:       begin v = ov0; p = op0;         s = os0; u = ou0; r = ir0; end
            1:       begin v = ov1; p = {24'd0, op1}; s = os1; u = ou1; r = ir1; end
            default: begin v = ov2; p = {24'd0, op2}; s = os2; u = ou2; r = ir2; end
        endcase
    endtask

    function automatic int ns_of(input int sel);
        return (sel == 0) ? 3 : (sel == 1) ? 1 : 2;
    endfunction

    task automatic run_vec(input vec_t t, input int idx);
        logic v, s, r;
        logic [31:0] p;
        logic [1:0] u;
        int lat;
        in_a = t.a; in_b = t.b; in_user = t.user;
        case (t.sel)
            0:       iv0 = 1'b1;
            1:       iv1 = 1'b1;
            default: iv2 = 1'b1;
        endcase
        #1;
        outs(t.sel, v, p, s, u, r);
        chk($sformatf("vec%0d in_ready", idx), r, 1);
        @(negedge clk);
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        lat = 1;
        outs(t.sel, v, p, s, u, r);
        while (!v && lat < 20) begin
            @(negedge clk);
            lat++;
            outs(t.sel, v, p, s, u, r);
        end
        chk($sformatf("vec%0d latency", idx), lat, ns_of(t.sel));
        chk($sformatf("vec%0d out_p", idx), p, t.p);
        chk($sformatf("vec%0d out_sat", idx), s, t.sat);
        chk($sformatf("vec%0d out_user", idx), u, t.user);
    endtask

    // Reference for u_dut3: signed a x unsigned b, round half up, >>3, clip to 10-bit signed.
    function automatic logic [10:0] model3(input logic [7:0] a, input logic [7:0] b);
        longint pr, q;
        logic [9:0] r;
        logic s;
        pr = longint'($signed(a)) * longint'(b);
        q  = (pr + 4) >>> 3;
        if (q > 511)       begin r = 10'h1FF; s = 1'b1; end
        else if (q < -512) begin r = 10'h200; s = 1'b1; end
        else               begin r = q[9:0];  s = 1'b0; end
        return {s, r};
    endfunction

    logic [12:0] sb[$];
    logic [13:0] held;
    logic        stall_prev = 1'b0;
    logic        last_acc = 1'b0;
    int          received3 = 0;

    task automatic cycle3(input logic v, input logic r);
        logic [12:0] want;
        if (stall_prev) chk("dut3 stable during stall", {ov3, os3, op3, ou3}, held);
        iv3 = v; or3 = r;
        #1;
        if (ov3 && or3) begin
            received3++;
            if (sb.size() == 0) chk("dut3 output with empty scoreboard", ov3, 0);
            else begin
                want = sb.pop_front();
                chk("dut3 result", {os3, op3, ou3}, want);
            end
        end
        last_acc = iv3 && ir3;
        if (last_acc) sb.push_back({model3(a3, b3), u3});
        stall_prev = ov3 && !or3;
        held = {ov3, os3, op3, ou3};
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tq[$];
        int got, first, bubbles, stalls, n, acc, rx0, sent, cyc, seen;
        logic pending;

        tv[0]  = '{0, 16'hFFFF, 16'hFFFF, 2'd1, 32'hFFFE0001, 1'b0};
        tv[1]  = '{0, 16'h0000, 16'h1234, 2'd2, 32'h00000000, 1'b0};
        tv[2]  = '{0, 16'h0001, 16'h0001, 2'd3, 32'h00000001, 1'b0};
        tv[3]  = '{0, 16'd300,  16'd200,  2'd0, 32'h0000EA60, 1'b0};
        tv[4]  = '{0, 16'hFFFF, 16'h0001, 2'd1, 32'h0000FFFF, 1'b0};
        tv[5]  = '{1, 16'h0080, 16'h0080, 2'd2, 32'h0000007F, 1'b1};
        tv[6]  = '{1, 16'h0040, 16'h0003, 2'd3, 32'h00000002, 1'b0};
        tv[7]  = '{1, 16'h0080, 16'h007F, 2'd0, 32'h00000081, 1'b0};
        tv[8]  = '{1, 16'h0001, 16'h0040, 2'd1, 32'h00000001, 1'b0};
        tv[9]  = '{1, 16'h00FF, 16'h0040, 2'd2, 32'h00000000, 1'b0};
        tv[10] = '{1, 16'h007F, 16'h007F, 2'd3, 32'h0000007E, 1'b0};
        tv[11] = '{1, 16'h0080, 16'h0064, 2'd0, 32'h0000009C, 1'b0};
        tv[12] = '{2, 16'h000F, 16'h0008, 2'd1, 32'h00000088, 1'b0};
        tv[13] = '{2, 16'h000F, 16'h0007, 2'd2, 32'h00000069, 1'b0};
        tv[14] = '{2, 16'h0000, 16'h0008, 2'd3, 32'h00000000, 1'b0};
        tv[15] = '{2, 16'h0008, 16'h000F, 2'd0, 32'h000000F8, 1'b0};

        in_a = '0; in_b = '0; in_user = '0;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
        a3 = '0; b3 = '0; u3 = '0;

        repeat (3) @(negedge clk);
        chk("reset out_valid", ov0, 0);
        chk("reset out_p", op0, 0);
        chk("reset out_sat", os0, 0);
        chk("reset out_user", ou0, 0);
        chk("reset in_ready", ir0, 0);
        rst_n = 1'b1;
        #1;
        chk("release in_ready", ir0, 1);
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(tv[i], i);
        repeat (4) @(negedge clk);

        // 100-beat back-to-back stream on the default configuration
        got = 0; first = -1; bubbles = 0; stalls = 0;
        for (int c = 0; c < 130 && got < 100; c++) begin
            if (c < 100) begin
                in_a = 16'(c + 1); in_b = 16'(c + 2); iv0 = 1'b1;
            end else iv0 = 1'b0;
            #1;
            if (ov0) begin
                if (first < 0) first = c;
                if (tq.size() == 0) chk("stream output with nothing sent", ov0, 0);
                else chk($sformatf("stream beat %0d", got), op0, tq.pop_front());
                got++;
            end else if (first >= 0) bubbles++;
            if (iv0 && !ir0) stalls++;
            if (iv0 && ir0) tq.push_back(32'(c + 1) * 32'(c + 2));
            @(negedge clk);
        end
        iv0 = 1'b0;
        chk("stream first latency", first, 3);
        chk("stream bubbles", bubbles, 0);
        chk("stream beats", got, 100);
        chk("stream input stalls", stalls, 0);

        // Fill with out_ready low, then drain while still accepting
        a3 = 8'd1; b3 = 8'd10; u3 = 2'd0; n = 0;
        for (int k = 0; k < 6; k++) begin
            cycle3(1'b1, 1'b0);
            if (last_acc) begin a3 = a3 + 8'd1; u3 = u3 + 2'd1; end
            if (last_acc) n++;
        end
        chk("fill accepted beats", n, 4);
        iv3 = 1'b1; or3 = 1'b0;
        #1;
        chk("fill in_ready when full", ir3, 0);
        or3 = 1'b1;
        #1;
        chk("fill in_ready follows out_ready", ir3, 1);
        acc = 0; rx0 = received3;
        for (int k = 0; k < 4; k++) begin
            cycle3(1'b1, 1'b1);
            if (last_acc) begin acc++; a3 = a3 + 8'd1; u3 = u3 + 2'd1; end
        end
        chk("drain accepts while emitting", acc, 4);
        chk("drain results emitted", received3 - rx0, 4);
        for (int k = 0; k < 10 && sb.size() != 0; k++) cycle3(1'b0, 1'b1);
        chk("drain scoreboard empty", sb.size(), 0);

        // Reset with beats in flight
        a3 = 8'd5; b3 = 8'd7; u3 = 2'd1;
        cycle3(1'b1, 1'b0); a3 = 8'd6;
        cycle3(1'b1, 1'b0); a3 = 8'd7;
        cycle3(1'b1, 1'b0);
        cycle3(1'b0, 1'b0);
        #2;
        chk("pre-reset out_valid", ov3, 1);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", ov3, 0);
        chk("mid reset out_p", op3, 0);
        chk("mid reset out_sat", os3, 0);
        chk("mid reset out_user", ou3, 0);
        chk("mid reset in_ready", ir3, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        stall_prev = 1'b0;
        #1;
        chk("post reset in_ready", ir3, 1);
        @(negedge clk);
        rx0 = received3; seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (ov3) seen++;
            cycle3(1'b0, 1'b1);
        end
        chk("no stale beat after reset", seen, 0);
        chk("no stale result after reset", received3 - rx0, 0);

        // Random valid/ready stream, 10k beats
        pending = 1'b0; sent = 0; cyc = 0;
        while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
            if (!pending && sent < 10000 && $urandom_range(0, 1) == 1) begin
                a3 = 8'($urandom); b3 = 8'($urandom); u3 = 2'($urandom);
                pending = 1'b1;
            end
            cycle3(pending, $urandom_range(0, 1) == 1);
            if (last_acc) begin pending = 1'b0; sent++; end
            cyc++;
        end
        chk("random beats sent", sent, 10000);
        chk("random scoreboard empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
